// File: rtl/spi_reg_ctrl.sv
// Register-map controller behind the soft SPI slave: decodes {rw, addr, data} frames into a
// double-buffered config bank, snapshotted status, W1C IRQ flags and an ID word.
module spi_reg_ctrl #(
  parameter int                ADDR_WIDTH = 7,
  parameter int                DATA_WIDTH = 24,
  parameter int                NUM_CFG    = 8,
  parameter int                NUM_STAT   = 4,
  parameter int                NUM_IRQ    = 8,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE = 24'h564E41
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [ADDR_WIDTH-1:0]          spi_addr,
  input  logic                           spi_addr_ready,
  input  logic                           spi_rw,
  input  logic [DATA_WIDTH-1:0]          spi_wdata,
  input  logic                           spi_data_ready,
  output logic [DATA_WIDTH-1:0]          spi_rdata,
  output logic [NUM_CFG*DATA_WIDTH-1:0]  cfg_flat,
  output logic                           cfg_update,
  input  logic                           cfg_busy,
  input  logic [NUM_STAT*DATA_WIDTH-1:0] stat_flat,
  input  logic [NUM_IRQ-1:0]             irq_set,
  output logic                           irq
);

  localparam logic [ADDR_WIDTH-1:0] A_STAT = ADDR_WIDTH'('h40);
  localparam logic [ADDR_WIDTH-1:0] A_MASK = ADDR_WIDTH'('h7C);
  localparam logic [ADDR_WIDTH-1:0] A_CTRL = ADDR_WIDTH'('h7D);
  localparam logic [ADDR_WIDTH-1:0] A_FLAG = ADDR_WIDTH'('h7E);
  localparam logic [ADDR_WIDTH-1:0] A_ID   = ADDR_WIDTH'('h7F);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_HOLD,
    S_WR_WAIT,
    S_WR_EXEC,
    S_WAIT_END
  } state_t;

  state_t                          state_q, state_d;
  logic [ADDR_WIDTH-1:0]           addr_q, addr_d;
  logic [DATA_WIDTH-1:0]           wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]           rdata_q, rdata_d;
  logic [DATA_WIDTH-1:0]           shadow_q [NUM_CFG];
  logic [DATA_WIDTH-1:0]           shadow_d [NUM_CFG];
  logic [NUM_CFG*DATA_WIDTH-1:0]   cfg_q, cfg_d;
  logic                            cfg_update_q, cfg_update_d;
  logic                            commit_pend_q, commit_pend_d;
  logic [NUM_IRQ-1:0]              irq_flags_q, irq_flags_d;
  logic [NUM_IRQ-1:0]              irq_mask_q, irq_mask_d;
  logic                            irq_q, irq_d;
  logic                            addr_prev_q, data_prev_q;

  logic                            addr_rise, data_rise;
  logic                            commit_req, commit_fire;
  logic [NUM_IRQ-1:0]              irq_clr;
  logic [DATA_WIDTH-1:0]           rd_val;

  assign addr_rise = spi_addr_ready & ~addr_prev_q;
  assign data_rise = spi_data_ready & ~data_prev_q;

  // Read mux works off the live address so the value can be registered on the addr_rise clock.
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NUM_CFG; i++)
      if (spi_addr == ADDR_WIDTH'(i)) rd_val = shadow_q[i];
    for (int i = 0; i < NUM_STAT; i++)
      if (spi_addr == A_STAT + ADDR_WIDTH'(i)) rd_val = stat_flat[i*DATA_WIDTH +: DATA_WIDTH];
    case (spi_addr)
      A_MASK:  rd_val = DATA_WIDTH'(irq_mask_q);
      A_CTRL:  rd_val = DATA_WIDTH'(commit_pend_q);
      A_FLAG:  rd_val = DATA_WIDTH'(irq_flags_q);
      A_ID:    rd_val = ID_VALUE;
      default: ;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    shadow_d     = shadow_q;
    cfg_d        = cfg_q;
    cfg_update_d = 1'b0;
    irq_mask_d   = irq_mask_q;
    commit_req   = 1'b0;
    irq_clr      = '0;

    case (state_q)
      S_IDLE: begin
        if (addr_rise) begin
          addr_d = spi_addr;
          if (spi_rw) begin
            rdata_d = rd_val;
            state_d = S_RD_HOLD;
          end else begin
            state_d = S_WR_WAIT;
          end
        end
      end
      S_RD_HOLD: begin
        if (!spi_addr_ready) state_d = S_IDLE;
      end
      S_WR_WAIT: begin
        if (!spi_addr_ready) begin
          state_d = S_IDLE;
        end else if (data_rise) begin
          wdata_d = spi_wdata;
          state_d = S_WR_EXEC;
        end
      end
      S_WR_EXEC: begin
        state_d = S_WAIT_END;
        for (int i = 0; i < NUM_CFG; i++)
          if (addr_q == ADDR_WIDTH'(i)) shadow_d[i] = wdata_q;
        if (addr_q == A_MASK) irq_mask_d = wdata_q[NUM_IRQ-1:0];
        if (addr_q == A_CTRL) commit_req = wdata_q[0];
        if (addr_q == A_FLAG) irq_clr = wdata_q[NUM_IRQ-1:0];
      end
      S_WAIT_END: begin
        if (!spi_addr_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Copy shadow_d so a shadow write landing on the commit clock is still included.
    commit_fire = commit_pend_q & ~cfg_busy;
    if (commit_fire) begin
      for (int i = 0; i < NUM_CFG; i++) cfg_d[i*DATA_WIDTH +: DATA_WIDTH] = shadow_d[i];
      cfg_update_d = 1'b1;
    end
    commit_pend_d = (commit_pend_q & ~commit_fire) | commit_req;

    irq_flags_d = (irq_flags_q & ~irq_clr) | irq_set;
    irq_d       = |(irq_flags_q & irq_mask_q);
  end

  // Edge history follows the inputs even in reset, so a frame already open at release is not seen as new.
  always_ff @(posedge clk) begin
    addr_prev_q <= spi_addr_ready;
    data_prev_q <= spi_data_ready;
    if (rst) begin
      state_q       <= S_IDLE;
      addr_q        <= '0;
      wdata_q       <= '0;
      rdata_q       <= '0;
      shadow_q      <= '{default: '0};
      cfg_q         <= '0;
      cfg_update_q  <= 1'b0;
      commit_pend_q <= 1'b0;
      irq_flags_q   <= '0;
      irq_mask_q    <= '0;
      irq_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      rdata_q       <= rdata_d;
      shadow_q      <= shadow_d;
      cfg_q         <= cfg_d;
      cfg_update_q  <= cfg_update_d;
      commit_pend_q <= commit_pend_d;
      irq_flags_q   <= irq_flags_d;
      irq_mask_q    <= irq_mask_d;
      irq_q         <= irq_d;
    end
  end

  assign spi_rdata  = rdata_q;
  assign cfg_flat   = cfg_q;
  assign cfg_update = cfg_update_q;
  assign irq        = irq_q;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Directed self-checking bench for spi_reg_ctrl: config commit, status snapshot, IRQ W1C,
// aborted frames and mid-frame reset.
module tb_spi_reg_ctrl;
  localparam int AW = 7;
  localparam int DW = 24;
  localparam int NC = 8;
  localparam int NS = 4;
  localparam int NI = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [AW-1:0]     spi_addr;
  logic              spi_addr_ready;
  logic              spi_rw;
  logic [DW-1:0]     spi_wdata;
  logic              spi_data_ready;
  logic [DW-1:0]     spi_rdata;
  logic [NC*DW-1:0]  cfg_flat;
  logic              cfg_update;
  logic              cfg_busy;
  logic [NS*DW-1:0]  stat_flat;
  logic [NI-1:0]     irq_set;
  logic              irq;

  int n_cmp = 0;
  int n_fail = 0;
  int upd_cnt = 0;

  spi_reg_ctrl dut (
    .clk(clk), .rst(rst),
    .spi_addr(spi_addr), .spi_addr_ready(spi_addr_ready), .spi_rw(spi_rw),
    .spi_wdata(spi_wdata), .spi_data_ready(spi_data_ready), .spi_rdata(spi_rdata),
    .cfg_flat(cfg_flat), .cfg_update(cfg_update), .cfg_busy(cfg_busy),
    .stat_flat(stat_flat), .irq_set(irq_set), .irq(irq)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (cfg_update === 1'b1) upd_cnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    spi_addr_ready = 1'b0;
    spi_data_ready = 1'b0;
    repeat (n) tick();
  endtask

  // Full write frame; returns just after the WR_EXEC clock, with frame strobes dropped.
  task automatic spi_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NI-1:0] set_at_exec);
    idle(2);
    spi_addr = a; spi_rw = 1'b0; spi_wdata = '0; spi_addr_ready = 1'b1;
    tick(); tick();
    spi_wdata = d; spi_data_ready = 1'b1;
    tick();
    irq_set = set_at_exec;
    tick();
    irq_set = '0;
    spi_addr_ready = 1'b0; spi_data_ready = 1'b0;
  endtask

  // Opens a read frame and returns one clock after addr_rise, frame still open.
  task automatic spi_read_start(input logic [AW-1:0] a);
    idle(2);
    spi_addr = a; spi_rw = 1'b1; spi_wdata = 24'hFFFFFF; spi_addr_ready = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    n_cmp++; if (spi_rdata !== 24'h0) begin n_fail++; $display("[TB] FAIL reset_rdata: got %h want 000000", spi_rdata); end
    n_cmp++; if (cfg_flat !== '0) begin n_fail++; $display("[TB] FAIL reset_cfg: got %h want 0", cfg_flat); end
    n_cmp++; if (cfg_update !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_update: got %b want 0", cfg_update); end
    n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_irq: got %b want 0", irq); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_commit();
    spi_write(7'h02, 24'hABCDEF, '0);
    tick();
    n_cmp++; if (cfg_flat[2*DW +: DW] !== 24'h0) begin n_fail++; $display("[TB] FAIL no_commit_reg2: got %h want 000000", cfg_flat[2*DW +: DW]); end
    spi_read_start(7'h02);
    n_cmp++; if (spi_rdata !== 24'hABCDEF) begin n_fail++; $display("[TB] FAIL shadow2_read: got %h want abcdef", spi_rdata); end
    idle(1);
    spi_write(7'h7D, 24'h000001, '0);
    n_cmp++; if (cfg_update !== 1'b0) begin n_fail++; $display("[TB] FAIL update_early: got %b want 0", cfg_update); end
    tick();
    n_cmp++; if (cfg_update !== 1'b1) begin n_fail++; $display("[TB] FAIL update_pulse: got %b want 1", cfg_update); end
    n_cmp++; if (cfg_flat[2*DW +: DW] !== 24'hABCDEF) begin n_fail++; $display("[TB] FAIL commit_reg2: got %h want abcdef", cfg_flat[2*DW +: DW]); end
    tick();
    n_cmp++; if (cfg_update !== 1'b0) begin n_fail++; $display("[TB] FAIL update_width: got %b want 0", cfg_update); end
  endtask

  task automatic test_busy_merge();
    int start;
    start = upd_cnt;
    cfg_busy = 1'b1;
    spi_write(7'h7D, 24'h000001, '0);
    spi_write(7'h7D, 24'h000001, '0);
    spi_write(7'h01, 24'h000005, '0);
    idle(3);
    n_cmp++; if (upd_cnt !== start) begin n_fail++; $display("[TB] FAIL busy_no_update: got %0d pulses want 0", upd_cnt - start); end
    n_cmp++; if (cfg_flat[1*DW +: DW] !== 24'h0) begin n_fail++; $display("[TB] FAIL busy_reg1: got %h want 000000", cfg_flat[1*DW +: DW]); end
    spi_read_start(7'h7D);
    n_cmp++; if (spi_rdata !== 24'h000001) begin n_fail++; $display("[TB] FAIL pend_read: got %h want 000001", spi_rdata); end
    idle(1);
    cfg_busy = 1'b0;
    tick();
    n_cmp++; if (cfg_update !== 1'b1) begin n_fail++; $display("[TB] FAIL busy_release_update: got %b want 1", cfg_update); end
    n_cmp++; if (cfg_flat[1*DW +: DW] !== 24'h000005) begin n_fail++; $display("[TB] FAIL merged_reg1: got %h want 000005", cfg_flat[1*DW +: DW]); end
    n_cmp++; if (cfg_flat[2*DW +: DW] !== 24'hABCDEF) begin n_fail++; $display("[TB] FAIL merged_reg2: got %h want abcdef", cfg_flat[2*DW +: DW]); end
    idle(4);
    n_cmp++; if (upd_cnt !== start + 1) begin n_fail++; $display("[TB] FAIL single_update: got %0d pulses want 1", upd_cnt - start); end
  endtask

  task automatic test_read_snapshot();
    stat_flat = {24'h444444, 24'h333333, 24'h222222, 24'h111111};
    spi_read_start(7'h7F);
    n_cmp++; if (spi_rdata !== 24'h564E41) begin n_fail++; $display("[TB] FAIL id_read: got %h want 564e41", spi_rdata); end
    spi_read_start(7'h40);
    n_cmp++; if (spi_rdata !== 24'h111111) begin n_fail++; $display("[TB] FAIL stat0_read: got %h want 111111", spi_rdata); end
    stat_flat[0 +: DW] = 24'h999999;
    repeat (3) tick();
    n_cmp++; if (spi_rdata !== 24'h111111) begin n_fail++; $display("[TB] FAIL stat0_snapshot: got %h want 111111", spi_rdata); end
    idle(2);
    n_cmp++; if (spi_rdata !== 24'h111111) begin n_fail++; $display("[TB] FAIL rdata_hold: got %h want 111111", spi_rdata); end
    spi_read_start(7'h43);
    n_cmp++; if (spi_rdata !== 24'h444444) begin n_fail++; $display("[TB] FAIL stat3_read: got %h want 444444", spi_rdata); end
    spi_read_start(7'h44);
    n_cmp++; if (spi_rdata !== 24'h0) begin n_fail++; $display("[TB] FAIL unmapped_44: got %h want 000000", spi_rdata); end
    spi_read_start(7'h08);
    n_cmp++; if (spi_rdata !== 24'h0) begin n_fail++; $display("[TB] FAIL unmapped_08: got %h want 000000", spi_rdata); end
    idle(1);
  endtask

  task automatic test_irq();
    spi_write(7'h7C, 24'h000001, '0);
    irq_set = 8'h01;
    tick();
    irq_set = '0;
    n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("[TB] FAIL irq_latency: got %b want 0", irq); end
    tick();
    n_cmp++; if (irq !== 1'b1) begin n_fail++; $display("[TB] FAIL irq_assert: got %b want 1", irq); end
    spi_write(7'h7E, 24'h000001, 8'h01);
    tick();
    n_cmp++; if (irq !== 1'b1) begin n_fail++; $display("[TB] FAIL set_wins_irq: got %b want 1", irq); end
    spi_read_start(7'h7E);
    n_cmp++; if (spi_rdata !== 24'h000001) begin n_fail++; $display("[TB] FAIL set_wins_flags: got %h want 000001", spi_rdata); end
    spi_write(7'h7E, 24'h000001, '0);
    n_cmp++; if (irq !== 1'b1) begin n_fail++; $display("[TB] FAIL clear_latency: got %b want 1", irq); end
    tick();
    n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("[TB] FAIL clear_irq: got %b want 0", irq); end
    irq_set = 8'h08;
    tick();
    irq_set = '0;
    tick(); tick();
    n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("[TB] FAIL masked_irq: got %b want 0", irq); end
    spi_read_start(7'h7E);
    n_cmp++; if (spi_rdata !== 24'h000008) begin n_fail++; $display("[TB] FAIL masked_flag: got %h want 000008", spi_rdata); end
    spi_write(7'h7E, 24'h000008, '0);
    spi_read_start(7'h7E);
    n_cmp++; if (spi_rdata !== 24'h0) begin n_fail++; $display("[TB] FAIL flags_cleared: got %h want 000000", spi_rdata); end
    idle(1);
  endtask

  task automatic test_abort();
    spi_write(7'h03, 24'h123456, '0);
    idle(2);
    spi_addr = 7'h03; spi_rw = 1'b0; spi_addr_ready = 1'b1;
    tick(); tick();
    spi_addr_ready = 1'b0;
    tick();
    spi_wdata = 24'hDEAD00; spi_data_ready = 1'b1;
    tick(); tick();
    idle(2);
    spi_read_start(7'h03);
    n_cmp++; if (spi_rdata !== 24'h123456) begin n_fail++; $display("[TB] FAIL abort_shadow3: got %h want 123456", spi_rdata); end
    spi_write(7'h05, 24'h55AA55, '0);
    spi_read_start(7'h05);
    n_cmp++; if (spi_rdata !== 24'h55AA55) begin n_fail++; $display("[TB] FAIL after_abort_frame: got %h want 55aa55", spi_rdata); end
    idle(1);
  endtask

  task automatic test_reset_midframe();
    int start;
    cfg_busy = 1'b1;
    spi_write(7'h7C, 24'h000001, 8'h01);
    spi_write(7'h7D, 24'h000001, '0);
    spi_write(7'h00, 24'h777777, '0);
    spi_read_start(7'h7F);
    idle(2);
    n_cmp++; if (irq !== 1'b1) begin n_fail++; $display("[TB] FAIL pre_reset_irq: got %b want 1", irq); end
    spi_addr = 7'h04; spi_rw = 1'b0; spi_addr_ready = 1'b1;
    tick(); tick();
    start = upd_cnt;
    rst = 1'b1; cfg_busy = 1'b0;
    tick();
    rst = 1'b0;
    n_cmp++; if (spi_rdata !== 24'h0) begin n_fail++; $display("[TB] FAIL midrst_rdata: got %h want 000000", spi_rdata); end
    n_cmp++; if (cfg_flat !== '0) begin n_fail++; $display("[TB] FAIL midrst_cfg: got %h want 0", cfg_flat); end
    n_cmp++; if (irq !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_irq: got %b want 0", irq); end
    spi_wdata = 24'hBAD000; spi_data_ready = 1'b1;
    tick(); tick(); tick();
    idle(2);
    n_cmp++; if (upd_cnt !== start) begin n_fail++; $display("[TB] FAIL midrst_no_update: got %0d pulses want 0", upd_cnt - start); end
    n_cmp++; if (cfg_flat !== '0) begin n_fail++; $display("[TB] FAIL midrst_cfg_after: got %h want 0", cfg_flat); end
    spi_read_start(7'h7D);
    n_cmp++; if (spi_rdata !== 24'h0) begin n_fail++; $display("[TB] FAIL midrst_pend: got %h want 000000", spi_rdata); end
    spi_read_start(7'h04);
    n_cmp++; if (spi_rdata !== 24'h0) begin n_fail++; $display("[TB] FAIL abandoned_write: got %h want 000000", spi_rdata); end
    spi_read_start(7'h00);
    n_cmp++; if (spi_rdata !== 24'h0) begin n_fail++; $display("[TB] FAIL midrst_shadow0: got %h want 000000", spi_rdata); end
    spi_write(7'h00, 24'h0000AA, '0);
    spi_write(7'h7D, 24'h000001, '0);
    tick();
    n_cmp++; if (cfg_update !== 1'b1) begin n_fail++; $display("[TB] FAIL post_rst_update: got %b want 1", cfg_update); end
    n_cmp++; if (cfg_flat[0 +: DW] !== 24'h0000AA) begin n_fail++; $display("[TB] FAIL post_rst_reg0: got %h want 0000aa", cfg_flat[0 +: DW]); end
    idle(2);
  endtask

  initial begin
    rst = 1'b1;
    spi_addr = '0; spi_addr_ready = 1'b0; spi_rw = 1'b0;
    spi_wdata = '0; spi_data_ready = 1'b0;
    cfg_busy = 1'b0; stat_flat = '0; irq_set = '0;
    test_reset();
    test_commit();
    test_busy_merge();
    test_read_snapshot();
    test_irq();
    test_abort();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
